// File: rtl/uart_transmitter_fifo.sv
// uart_transmitter_fifo
// FIFO-buffered UART transmitter. Bytes written with rx_new_byte are queued
// and serialised back to back: start bit, data_bits data bits (LSB first),
// optional parity bit, stop_bits stop bits. Bit period is
// comm_clk_frequency/baud_rate clocks.
// Optional feature macro: UART_TX_PARITY_EN (inserts the parity bit; parity
// sense chosen by parity_odd). Default build has no parity bit.
// The line output is registered from the current FSM state, so the line
// trails the FSM by one clock. tx_done is registered the same way, which
// puts its pulse on the line's last stop-bit clock.

module uart_transmitter_fifo #(
  parameter int unsigned comm_clk_frequency = 100000000,
  parameter int unsigned baud_rate          = 115200,
  parameter int unsigned data_bits          = 8,
  parameter int unsigned stop_bits          = 1,
  parameter int unsigned fifo_depth_log2    = 4,
  parameter bit          parity_odd         = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     uart_tx,
  input  logic                     rx_new_byte,
  input  logic [7:0]               rx_byte,
  output logic                     tx_ready,
  output logic [fifo_depth_log2:0] fifo_level,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic                     overflow
);

  localparam int unsigned AW         = fifo_depth_log2;
  localparam int unsigned DEPTH      = 2 ** AW;
  localparam int unsigned BIT_PERIOD = comm_clk_frequency / baud_rate;
  localparam logic [15:0] BAUD_DELAY = 16'(BIT_PERIOD - 1);
  localparam logic [2:0]  LAST_DATA  = 3'(data_bits - 1);
  localparam logic [2:0]  LAST_STOP  = 3'(stop_bits - 1);
  localparam logic [7:0]  DATA_MASK  = 8'((32'd1 << data_bits) - 32'd1);
  localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        overflow_q, overflow_d;

  // Transmit FSM state
  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  shift_q, shift_d;
  logic        uart_tx_q, uart_tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_done_q, tx_done_d;
  logic        bit_end;

  // Head-of-FIFO word: masked data with the parity bit placed just above it
  logic [7:0]  head_byte;
  logic [7:0]  head_data;
  logic        head_parity;
  logic [8:0]  head_word;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (level == FULL_LEVEL);
  assign fifo_empty = (level == '0);
  assign push       = rx_new_byte && !fifo_full;

  assign head_byte   = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_data   = head_byte & DATA_MASK;
  assign head_parity = (^head_data) ^ parity_odd;
  assign head_word   = {1'b0, head_data} | ({8'b0, head_parity} << data_bits);

  assign uart_tx    = uart_tx_q;
  assign tx_ready   = !fifo_full;
  assign fifo_level = level;
  assign tx_busy    = tx_busy_q;
  assign tx_done    = tx_done_q;
  assign overflow   = overflow_q;

  // Pointer advance on push/pop; sticky overflow on a write into a full FIFO
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d = overflow_q | (rx_new_byte & fifo_full);
  end

  // FIFO pointer and overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO data storage (no reset needed, pointers define validity)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= rx_byte;
    end
  end

  // Frame sequencing, bit timing and next line value
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    pop        = 1'b0;
    uart_tx_d  = 1'b1;
    bit_end    = (baud_cnt_q == BAUD_DELAY);

    case (state_q)
      IDLE: begin
        uart_tx_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = head_word;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_busy_d  = 1'b1;
          state_d    = START;
        end
      end

      START: begin
        uart_tx_d = 1'b0;
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      DATA: begin
        uart_tx_d = shift_q[0];
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b1, shift_q[8:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        uart_tx_d = shift_q[0];
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
`endif

      STOP: begin
        uart_tx_d = 1'b1;
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            tx_done_d = 1'b1;
            // Chain straight into the next start bit when data is waiting
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head_word;
              state_d = START;
            end else begin
              tx_busy_d = 1'b0;
              state_d   = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      default: begin
        uart_tx_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
      uart_tx_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// Testbench for uart_transmitter_fifo. Two instances: A (8N1-style, 4-clock
// bits, 16-deep FIFO, odd parity sense) and B (7 data, 2 stop, 3-clock bits,
// 4-deep FIFO, even parity sense). A line monitor per instance captures
// frames; tasks compare them against frames and start times derived from
// the frame rules.

module tb_uart_transmitter_fifo;

  localparam int PA = 4, NBA = 8, NSA = 1, DA = 16;
  localparam int PB = 3, NBB = 7, NSB = 2, DB = 4;
  localparam bit ODDA = 1'b1, ODDB = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FA = 1 + NBA + PAR + NSA;
  localparam int FB = 1 + NBB + PAR + NSB;

  typedef struct {
    logic [11:0] bits;
    int          start;
    bit          stable;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_tx, a_new, a_ready, a_busy, a_done, a_ovf;
  logic [7:0] a_byte;
  logic [4:0] a_level;
  logic       b_tx, b_new, b_ready, b_busy, b_done, b_ovf;
  logic [7:0] b_byte;
  logic [2:0] b_level;

  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  bit     ovf_seen [2];
  frame_t qa [$];
  frame_t qb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transmitter_fifo #(
    .comm_clk_frequency(4), .baud_rate(1), .data_bits(NBA), .stop_bits(NSA),
    .fifo_depth_log2(4), .parity_odd(ODDA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_tx(a_tx), .rx_new_byte(a_new),
    .rx_byte(a_byte), .tx_ready(a_ready), .fifo_level(a_level),
    .tx_busy(a_busy), .tx_done(a_done), .overflow(a_ovf)
  );

  uart_transmitter_fifo #(
    .comm_clk_frequency(9), .baud_rate(3), .data_bits(NBB), .stop_bits(NSB),
    .fifo_depth_log2(2), .parity_odd(ODDB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_tx(b_tx), .rx_new_byte(b_new),
    .rx_byte(b_byte), .tx_ready(b_ready), .fifo_level(b_level),
    .tx_busy(b_busy), .tx_done(b_done), .overflow(b_ovf)
  );

  function automatic logic line(input int inst);
    return (inst == 0) ? a_tx : b_tx;
  endfunction

  function automatic int qsize(input int inst);
    return (inst == 0) ? qa.size() : qb.size();
  endfunction

  function automatic frame_t qget(input int inst, input int k);
    return (inst == 0) ? qa[k] : qb[k];
  endfunction

  // Expected frame bits, index 0 = first bit on the line
  function automatic logic [11:0] exp_bits(input int inst, input logic [7:0] v);
    logic [11:0] f;
    int nb, ns, k, ones;
    bit odd;
    nb = (inst == 0) ? NBA : NBB;
    ns = (inst == 0) ? NSA : NSB;
    odd = (inst == 0) ? ODDA : ODDB;
    f = '0; k = 1; ones = 0;
    for (int i = 0; i < nb; i++) begin
      f[k] = v[i]; ones += int'(v[i]); k++;
    end
    if (PAR == 1) begin
      f[k] = 1'(ones % 2) ^ odd; k++;
    end
    for (int i = 0; i < ns; i++) begin
      f[k] = 1'b1; k++;
    end
    return f;
  endfunction

  task automatic monitor(input int inst);
    frame_t fr;
    bit aborted;
    int p, f;
    p = (inst == 0) ? PA : PB;
    f = (inst == 0) ? FA : FB;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && line(inst) === 1'b0) begin
        fr.bits = '0; fr.start = cyc; fr.stable = 1'b1; aborted = 1'b0;
        for (int b = 0; b < f; b++) begin
          for (int c = 0; c < p; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            if (c == 0) fr.bits[b] = line(inst);
            else if (line(inst) !== fr.bits[b]) fr.stable = 1'b0;
          end
        end
        if (!aborted) begin
          if (inst == 0) qa.push_back(fr); else qb.push_back(fr);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One write strobe; wc = cycle count right after the sampling edge
  task automatic put(input int inst, input logic [7:0] v, output int wc);
    if (inst == 0) begin a_new = 1'b1; a_byte = v; end
    else begin b_new = 1'b1; b_byte = v; end
    tick();
    a_new = 1'b0; b_new = 1'b0;
    wc = cyc;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 3000;
    while ((a_busy || b_busy || a_level != 0 || b_level != 0) && budget > 0) begin
      tick(); budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++; $display("FAIL idle_timeout: still busy, want idle");
    end
    repeat (4) tick();
    qa.delete(); qb.delete();
  endtask

  task automatic test_reset();
    a_new = 1'b0; b_new = 1'b0; a_byte = '0; b_byte = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (a_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", a_tx); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", a_level); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
    checks++;
    if ({b_tx, b_ready, b_level, b_busy, b_done, b_ovf} !== 8'b1100_0000) begin
      errors++; $display("FAIL reset_b: got %b want 11000000", {b_tx, b_ready, b_level, b_busy, b_done, b_ovf});
    end
  endtask

  task automatic test_single_frame();
    int w, busy_n, done_n, done_at;
    frame_t fr;
    wait_idle();
    put(0, 8'hA5, w);
    checks++; if (a_level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", a_level); end
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < FA * PA + 10; i++) begin
      @(negedge clk);
      if (a_busy === 1'b1) busy_n++;
      if (a_done === 1'b1) begin done_n++; done_at = cyc; end
    end
    tick();
    checks++;
    if (qa.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", qa.size());
    end else begin
      fr = qa[0];
      checks++; if (fr.bits !== exp_bits(0, 8'hA5)) begin errors++; $display("FAIL single_bits: got %b want %b", fr.bits, exp_bits(0, 8'hA5)); end
      checks++; if (fr.start != w + 2) begin errors++; $display("FAIL single_start: got %0d want %0d", fr.start, w + 2); end
      checks++; if (!fr.stable) begin errors++; $display("FAIL single_bitwidth: got unstable want %0d clocks per bit", PA); end
      checks++; if (done_at != w + 1 + FA * PA) begin errors++; $display("FAIL single_done_at: got %0d want %0d", done_at, w + 1 + FA * PA); end
    end
    checks++; if (busy_n != FA * PA) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", busy_n, FA * PA); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_n); end
  endtask

  task automatic test_back_to_back();
    int w0, w1, budget;
    wait_idle();
    put(0, 8'h55, w0);
    checks++; if (a_level !== 5'd1) begin errors++; $display("FAIL b2b_level0: got %0d want 1", a_level); end
    put(0, 8'h0F, w1);
    checks++; if (a_level !== 5'd1) begin errors++; $display("FAIL b2b_level1: got %0d want 1", a_level); end
    while (cyc < w0 + FA * PA) tick();
    checks++; if (a_level !== 5'd1) begin errors++; $display("FAIL b2b_level_prepop: got %0d want 1", a_level); end
    tick();
    checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL b2b_level_pop: got %0d want 0", a_level); end
    budget = 3 * FA * PA;
    while (qa.size() < 2 && budget > 0) begin tick(); budget--; end
    checks++;
    if (qa.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d want 2", qa.size());
    end else begin
      checks++; if (qa[0].bits !== exp_bits(0, 8'h55)) begin errors++; $display("FAIL b2b_bits0: got %b want %b", qa[0].bits, exp_bits(0, 8'h55)); end
      checks++; if (qa[1].bits !== exp_bits(0, 8'h0F)) begin errors++; $display("FAIL b2b_bits1: got %b want %b", qa[1].bits, exp_bits(0, 8'h0F)); end
      checks++; if (qa[0].start != w0 + 2) begin errors++; $display("FAIL b2b_start0: got %0d want %0d", qa[0].start, w0 + 2); end
      checks++; if (qa[1].start != qa[0].start + FA * PA) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", qa[1].start, qa[0].start + FA * PA); end
    end
  endtask

  task automatic test_push_on_pop();
    logic [7:0] vals [5];
    int w0, w, budget;
    wait_idle();
    vals[0] = 8'h03;
    for (int i = 1; i < 5; i++) vals[i] = 8'($urandom_range(0, 255));
    put(1, vals[0], w0);
    for (int i = 1; i < 4; i++) put(1, vals[i], w);
    checks++; if (b_level !== 3'd3) begin errors++; $display("FAIL pop_level_pre: got %0d want 3", b_level); end
    while (cyc < w0 + FB * PB) tick();
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL pop_ready: got %b want 1", b_ready); end
    put(1, vals[4], w);
    checks++; if (b_level !== 3'd3) begin errors++; $display("FAIL pop_level_post: got %0d want 3", b_level); end
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL pop_ovf: got %b want 0", b_ovf); end
    budget = 6 * FB * PB;
    while (qb.size() < 5 && budget > 0) begin tick(); budget--; end
    checks++;
    if (qb.size() != 5) begin
      errors++; $display("FAIL pop_count: got %0d want 5", qb.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (qb[k].bits !== exp_bits(1, vals[k])) begin errors++; $display("FAIL pop_bits%0d: got %b want %b", k, qb[k].bits, exp_bits(1, vals[k])); end
        checks++; if (qb[k].start != w0 + 2 + k * FB * PB) begin errors++; $display("FAIL pop_start%0d: got %0d want %0d", k, qb[k].start, w0 + 2 + k * FB * PB); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [6];
    int w0, w, budget;
    wait_idle();
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", b_ovf); end
    for (int i = 0; i < 6; i++) vals[i] = 8'($urandom_range(0, 255));
    put(1, vals[0], w0);
    for (int i = 1; i < 5; i++) put(1, vals[i], w);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", b_ready); end
    checks++; if (b_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", b_level); end
    put(1, vals[5], w);
    ovf_seen[1] = 1'b1;
    checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", b_ovf); end
    checks++; if (b_level !== 3'd4) begin errors++; $display("FAIL ovf_level_after: got %0d want 4", b_level); end
    budget = 7 * FB * PB;
    while (qb.size() < 5 && budget > 0) begin tick(); budget--; end
    repeat (2 * FB * PB) tick();
    checks++;
    if (qb.size() != 5) begin
      errors++; $display("FAIL ovf_count: got %0d want 5", qb.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (qb[k].bits !== exp_bits(1, vals[k])) begin errors++; $display("FAIL ovf_bits%0d: got %b want %b", k, qb[k].bits, exp_bits(1, vals[k])); end
        checks++; if (qb[k].start != w0 + 2 + k * FB * PB) begin errors++; $display("FAIL ovf_start%0d: got %0d want %0d", k, qb[k].start, w0 + 2 + k * FB * PB); end
      end
    end
    checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", b_ovf); end
  endtask

  // Acceptance and start times from queue occupancy and frame length
  task automatic test_random(input int inst, input int n, input int maxgap);
    int f, p, depth, w, lvl, budget, st;
    int sq [$];
    logic [7:0] vq [$];
    logic [7:0] v;
    bit rej;
    frame_t fr;
    f = (inst == 0) ? FA : FB;
    p = (inst == 0) ? PA : PB;
    depth = (inst == 0) ? DA : DB;
    wait_idle();
    rej = 1'b0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      v = 8'($urandom_range(0, 255));
      put(inst, v, w);
      lvl = 0;
      foreach (sq[j]) if (sq[j] - 1 >= w) lvl++;
      if (lvl < depth) begin
        st = w + 2;
        if (sq.size() > 0 && sq[$] + f * p > st) st = sq[$] + f * p;
        sq.push_back(st); vq.push_back(v);
      end else begin
        rej = 1'b1;
      end
    end
    if (rej) ovf_seen[inst] = 1'b1;
    budget = (n + 2) * f * p + 50;
    while (qsize(inst) < sq.size() && budget > 0) begin tick(); budget--; end
    repeat (2 * f * p) tick();
    checks++;
    if (qsize(inst) != sq.size()) begin
      errors++; $display("FAIL rand%0d_count: got %0d want %0d", inst, qsize(inst), sq.size());
    end else begin
      foreach (sq[k]) begin
        fr = qget(inst, k);
        checks++; if (fr.bits !== exp_bits(inst, vq[k])) begin errors++; $display("FAIL rand%0d_bits%0d: got %b want %b", inst, k, fr.bits, exp_bits(inst, vq[k])); end
        checks++; if (fr.start != sq[k]) begin errors++; $display("FAIL rand%0d_start%0d: got %0d want %0d", inst, k, fr.start, sq[k]); end
        checks++; if (!fr.stable) begin errors++; $display("FAIL rand%0d_bitwidth%0d: got unstable want %0d clocks per bit", inst, k, p); end
      end
    end
    checks++;
    if (((inst == 0) ? a_ovf : b_ovf) !== ovf_seen[inst]) begin
      errors++; $display("FAIL rand%0d_ovf: got %b want %b", inst, (inst == 0) ? a_ovf : b_ovf, ovf_seen[inst]);
    end
  endtask

  task automatic test_reset_midframe();
    int w0, w, lows, busy_n;
    wait_idle();
    put(0, 8'hC3, w0);
    for (int i = 0; i < 3; i++) put(0, 8'($urandom_range(0, 255)), w);
    while (cyc < w0 + 2 + 4 * PA + 1) tick();
    checks++; if (a_level !== 5'd3) begin errors++; $display("FAIL rstmid_level_pre: got %0d want 3", a_level); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", a_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", a_tx); end
    checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", a_level); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    lows = 0; busy_n = 0;
    for (int i = 0; i < 3 * FA * PA; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1) lows++;
      if (a_busy !== 1'b0) busy_n++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_line_quiet: got %0d low clocks want 0", lows); end
    checks++; if (busy_n != 0) begin errors++; $display("FAIL rstmid_busy_after: got %0d busy clocks want 0", busy_n); end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL rstmid_frames: got %0d want 0", qa.size()); end
  endtask

  initial begin
    a_new = 1'b0; b_new = 1'b0; a_byte = '0; b_byte = '0;
    ovf_seen[0] = 1'b0; ovf_seen[1] = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_push_on_pop();
    test_overflow();
    test_random(0, 24, 2);
    test_random(1, 12, 12);
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter_fifo.md
Name: uart_transmitter_fifo

Overview:
Parametrised, buffered successor to the single-byte UART transmitter used on the miner comm link. Accepts bytes through a write strobe into an internal FIFO and serialises them back to back. Frame format is set by parameters: data bits, stop bits and optional parity. Sits between the result/reporting logic and the board UART TX pin.

Parameters:
comm_clk_frequency, 100000000, clk frequency in Hz
baud_rate, 115200, line rate; bit period = comm_clk_frequency/baud_rate clocks, baud_delay = that minus 1, 16 bits
data_bits, 8, data bits per frame, legal 5..8; rx_byte bits above data_bits-1 ignored
stop_bits, 1, stop bits per frame, legal 1 or 2
fifo_depth_log2, 4, FIFO depth = 2**fifo_depth_log2 entries of 8 bits
parity_odd, 0, 0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
uart_tx  output  1  serial line, idles high
rx_new_byte  input  1  write strobe, one byte per high cycle
rx_byte  input  8  byte to send, sampled when rx_new_byte high
tx_ready  output  1  high when FIFO not full (write will be accepted)
fifo_level  output  fifo_depth_log2+1  bytes held in FIFO, not counting the byte being shifted
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse at end of each frame's last stop bit
overflow  output  1  sticky; set when rx_new_byte arrives with tx_ready low

Behaviour:
- Reset (async assert, sync release): uart_tx=1, tx_ready=1, fifo_level=0, tx_busy=0, tx_done=0, overflow=0, FIFO pointers 0, state IDLE, baud counter 0.
- Write: rx_new_byte && tx_ready -> byte stored, fifo_level+1 next cycle. rx_new_byte && !tx_ready -> byte dropped, overflow<=1 (cleared only by reset).
- Full FIFO: tx_ready low even if a pop occurs the same cycle (no write-through on full). Simultaneous push and pop otherwise legal; fifo_level unchanged.
- Pointers wrap modulo 2**fifo_depth_log2; level computed with extra MSB, so full = level == depth.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty, pop head into shift register, clear baud counter, go START, tx_busy<=1. Byte written at edge E into an empty FIFO with FSM idle: pop at E+1, uart_tx low after E+2.
- Each bit lasts exactly baud_delay+1 clocks; baud counter clears on every bit boundary.
- START: uart_tx=0 for one bit -> DATA.
- DATA: data_bits bits, LSB first -> PARITY if enabled, else STOP.
- PARITY: one bit, XOR of the sent data bits (inverted if parity_odd=1) -> STOP.
- STOP: uart_tx=1 for stop_bits bit periods. On the final cycle: tx_done=1; if FIFO non-empty, pop and enter START so the next start bit follows with zero idle gap; else IDLE, tx_busy<=0.
- Writes during a frame never disturb the frame in flight.
- Reset mid-frame: line returns high immediately; queued bytes discarded.

Optional Feature:
UART_TX_PARITY_EN: defined -> PARITY state and bit inserted per parity_odd; frame = 1+data_bits+1+stop_bits bits. Undefined -> PARITY state absent, parity_odd ignored, frame = 1+data_bits+stop_bits bits.

Test Plan:
- Defaults, baud_delay forced to 3 (bit period 4 clocks), write 0xA5 once -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 clocks; tx_done pulses once on the final stop cycle; tx_busy spans 40 clocks.
- Write 0x55 then 0x0F on consecutive cycles -> two frames with no idle gap between the stop bit and the next start bit; fifo_level goes 1,1,0 at the pops.
- fifo_depth_log2=2, 6 writes on consecutive cycles while idle -> 1 popped, 4 queued, tx_ready low, 6th write dropped, overflow=1; five frames transmitted.
- UART_TX_PARITY_EN, parity_odd=0, data_bits=7, stop_bits=2, send 0x03 -> 1100000 data bits, parity 0, two stop bits, 11-bit frame.
- Assert rst_n low during the 4th data bit with 3 bytes queued -> uart_tx=1 immediately, fifo_level=0, tx_busy=0; no further frames after release.
- Write on the same cycle as a pop with FIFO at depth-1 -> accepted, level unchanged, no overflow.
